// File: rtl/tlp_pkg.sv
// Shared definitions for the TLP stream detector: K-symbol codes, fmt/type
// encodings, the decoded kind enum and the framing state enum.
package tlp_pkg;

  localparam logic [7:0] STP = 8'hFB;
  localparam logic [7:0] END = 8'hFD;
  localparam logic [7:0] EDB = 8'hFE;

  localparam logic [7:0] FT_MRD32  = 8'h00;
  localparam logic [7:0] FT_MRD64  = 8'h20;
  localparam logic [7:0] FT_MWR32  = 8'h40;
  localparam logic [7:0] FT_MWR64  = 8'h60;
  localparam logic [7:0] FT_IORD   = 8'h02;
  localparam logic [7:0] FT_IOWR   = 8'h42;
  localparam logic [7:0] FT_CFGRD0 = 8'h04;
  localparam logic [7:0] FT_CFGWR0 = 8'h44;
  localparam logic [7:0] FT_CFGRD1 = 8'h05;
  localparam logic [7:0] FT_CFGWR1 = 8'h45;
  localparam logic [7:0] FT_CPL    = 8'h0A;
  localparam logic [7:0] FT_CPLD   = 8'h4A;

  typedef enum logic [3:0] {
    MRD     = 4'd0,
    MWR     = 4'd1,
    IORD    = 4'd2,
    IOWR    = 4'd3,
    CFGRD0  = 4'd4,
    CFGWR0  = 4'd5,
    CFGRD1  = 4'd6,
    CFGWR1  = 4'd7,
    CPL     = 4'd8,
    CPLD    = 4'd9,
    UNKNOWN = 4'd15
  } tlp_kind_e;

  typedef enum logic [1:0] {
    IDLE,
    FRAME,
    DISCARD
  } det_state_e;

endpackage

// File: rtl/tlp_stream_detector_if.sv
// Output stream of the TLP detector: one held TLP with a valid/ready handshake.
interface tlp_stream_detector_if
  import tlp_pkg::*;
#(
  parameter int MAX_BYTES = 20
) ();

  localparam int LEN_W = $clog2(MAX_BYTES + 1);

  logic                   tlp_valid;
  logic                   tlp_ready;
  logic [MAX_BYTES*8-1:0] tlp_data;
  logic [LEN_W-1:0]       tlp_len;
  tlp_kind_e              tlp_kind;

  modport master (
    output tlp_valid,
    output tlp_data,
    output tlp_len,
    output tlp_kind,
    input  tlp_ready
  );

  modport slave (
    input  tlp_valid,
    input  tlp_data,
    input  tlp_len,
    input  tlp_kind,
    output tlp_ready
  );

endinterface

// File: rtl/tlp_type_decoder.sv
// Combinational decode of the TLP fmt/type byte into a kind code.
module tlp_type_decoder
  import tlp_pkg::*;
(
  input  logic [7:0] type_byte,
  output tlp_kind_e  kind
);

  always_comb begin
    kind = UNKNOWN;
    case (type_byte)
      FT_MRD32, FT_MRD64: kind = MRD;
      FT_MWR32, FT_MWR64: kind = MWR;
      FT_IORD:            kind = IORD;
      FT_IOWR:            kind = IOWR;
      FT_CFGRD0:          kind = CFGRD0;
      FT_CFGWR0:          kind = CFGWR0;
      FT_CFGRD1:          kind = CFGRD1;
      FT_CFGWR1:          kind = CFGWR1;
      FT_CPL:             kind = CPL;
      FT_CPLD:            kind = CPLD;
      default:            kind = UNKNOWN;
    endcase
  end

endmodule

// File: rtl/tlp_stream_detector.sv
// Byte-serial TLP framer: assembles STP..END frames, validates length, decodes
// the kind and hands good TLPs to a one-entry valid/ready holding buffer.
module tlp_stream_detector
  import tlp_pkg::*;
#(
  parameter int MAX_BYTES   = 20,
  parameter int MIN_BYTES   = 12,
  parameter int TYPE_OFFSET = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       data_in,
  input  logic             datak,
  tlp_stream_detector_if.master tlp_out,
  output logic             MRd,
  output logic             MWr,
  output logic             IORd,
  output logic             IOWr,
  output logic             CfgRd0,
  output logic             CfgWr0,
  output logic             CfgRd1,
  output logic             CfgWr1,
  output logic             Cpl,
  output logic             CplD,
  output logic [CNT_W-1:0] tlp_count,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] drop_count,
  output logic [CNT_W-1:0] nullified_count
);

  localparam int IDX_W = $clog2(MAX_BYTES + 1);
  localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(MAX_BYTES);
  localparam logic [IDX_W-1:0] MIN_IDX = IDX_W'(MIN_BYTES);

  det_state_e             state_q, state_d;
  logic [IDX_W-1:0]       idx_q;
  logic [MAX_BYTES*8-1:0] frame_q;
  tlp_kind_e              frame_kind;

  logic                   buf_valid_q;
  logic [MAX_BYTES*8-1:0] buf_data_q;
  logic [IDX_W-1:0]       buf_len_q;
  tlp_kind_e              buf_kind_q;

  logic start_frame, store_byte, frame_done, frame_err, frame_null, buf_load;
  logic [CNT_W-1:0] tlp_cnt_q, err_cnt_q, drop_cnt_q, null_cnt_q;

  tlp_type_decoder u_type_decoder (
    .type_byte (frame_q[TYPE_OFFSET*8 +: 8]),
    .kind      (frame_kind)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    start_frame = 1'b0;
    store_byte  = 1'b0;
    frame_done  = 1'b0;
    frame_err   = 1'b0;
    frame_null  = 1'b0;
    case (state_q)
      IDLE: begin
        if (datak && data_in == STP) begin
          state_d     = FRAME;
          start_frame = 1'b1;
        end
      end
      FRAME: begin
        if (!datak) begin
          if (idx_q == MAX_IDX) begin
            frame_err = 1'b1;
            state_d   = DISCARD;
          end else begin
            store_byte = 1'b1;
          end
        end else begin
          case (data_in)
            END: begin
              state_d = IDLE;
              if (idx_q >= MIN_IDX) frame_done = 1'b1;
              else                  frame_err  = 1'b1;
            end
            EDB: begin
              state_d    = IDLE;
              frame_null = 1'b1;
            end
            STP: begin
              frame_err   = 1'b1;
              start_frame = 1'b1;
            end
            default: begin
              frame_err = 1'b1;
              state_d   = DISCARD;
            end
          endcase
        end
      end
      DISCARD: begin
        if (datak) begin
          if (data_in == END || data_in == EDB) begin
            state_d = IDLE;
          end else if (data_in == STP) begin
            state_d     = FRAME;
            start_frame = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Clearing on STP keeps bytes beyond the frame length at zero in the buffer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q   <= '0;
      frame_q <= '0;
    end else if (start_frame) begin
      idx_q   <= '0;
      frame_q <= '0;
    end else if (store_byte) begin
      for (int b = 0; b < MAX_BYTES; b++) begin
        if (idx_q == IDX_W'(b)) frame_q[b*8 +: 8] <= data_in;
      end
      idx_q <= idx_q + 1'b1;
    end
  end

  assign buf_load = frame_done & (~buf_valid_q | tlp_out.tlp_ready);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_valid_q <= 1'b0;
      buf_data_q  <= '0;
      buf_len_q   <= '0;
      buf_kind_q  <= MRD;
    end else if (buf_load) begin
      buf_valid_q <= 1'b1;
      buf_data_q  <= frame_q;
      buf_len_q   <= idx_q;
      buf_kind_q  <= frame_kind;
    end else if (buf_valid_q && tlp_out.tlp_ready) begin
      buf_valid_q <= 1'b0;
    end
  end

  // Statistics saturate at all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tlp_cnt_q  <= '0;
      err_cnt_q  <= '0;
      drop_cnt_q <= '0;
      null_cnt_q <= '0;
    end else begin
      if (buf_load && tlp_cnt_q != '1)                 tlp_cnt_q  <= tlp_cnt_q + 1'b1;
      if (frame_done && !buf_load && drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 1'b1;
      if (frame_err && err_cnt_q != '1)                err_cnt_q  <= err_cnt_q + 1'b1;
      if (frame_null && null_cnt_q != '1)              null_cnt_q <= null_cnt_q + 1'b1;
    end
  end

  assign tlp_out.tlp_valid = buf_valid_q;
  assign tlp_out.tlp_data  = buf_data_q;
  assign tlp_out.tlp_len   = buf_len_q;
  assign tlp_out.tlp_kind  = buf_kind_q;

  assign MRd    = buf_valid_q && (buf_kind_q == MRD);
  assign MWr    = buf_valid_q && (buf_kind_q == MWR);
  assign IORd   = buf_valid_q && (buf_kind_q == IORD);
  assign IOWr   = buf_valid_q && (buf_kind_q == IOWR);
  assign CfgRd0 = buf_valid_q && (buf_kind_q == CFGRD0);
  assign CfgWr0 = buf_valid_q && (buf_kind_q == CFGWR0);
  assign CfgRd1 = buf_valid_q && (buf_kind_q == CFGRD1);
  assign CfgWr1 = buf_valid_q && (buf_kind_q == CFGWR1);
  assign Cpl    = buf_valid_q && (buf_kind_q == CPL);
  assign CplD   = buf_valid_q && (buf_kind_q == CPLD);

  assign tlp_count       = tlp_cnt_q;
  assign err_count       = err_cnt_q;
  assign drop_count      = drop_cnt_q;
  assign nullified_count = null_cnt_q;

endmodule

// File: tb/tb_tlp_stream_detector.sv
// Directed bench for tlp_stream_detector: a vector table of back-to-back frames
// plus hand-written sequences for restart, backpressure, reset and saturation.
module tb_tlp_stream_detector;
  import tlp_pkg::*;

  localparam int MAX_BYTES   = 20;
  localparam int MIN_BYTES   = 12;
  localparam int TYPE_OFFSET = 2;
  localparam int CNT_W       = 8;
  localparam int DW          = MAX_BYTES * 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic datak = 1'b0;
  logic MRd, MWr, IORd, IOWr, CfgRd0, CfgWr0, CfgRd1, CfgWr1, Cpl, CplD;
  logic [CNT_W-1:0] tlp_count, err_count, drop_count, nullified_count;
  logic [9:0] strb;

  tlp_stream_detector_if #(.MAX_BYTES(MAX_BYTES)) tlp_bus ();

  tlp_stream_detector #(
    .MAX_BYTES(MAX_BYTES), .MIN_BYTES(MIN_BYTES),
    .TYPE_OFFSET(TYPE_OFFSET), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .datak(datak),
    .tlp_out(tlp_bus.master),
    .MRd(MRd), .MWr(MWr), .IORd(IORd), .IOWr(IOWr),
    .CfgRd0(CfgRd0), .CfgWr0(CfgWr0), .CfgRd1(CfgRd1), .CfgWr1(CfgWr1),
    .Cpl(Cpl), .CplD(CplD),
    .tlp_count(tlp_count), .err_count(err_count),
    .drop_count(drop_count), .nullified_count(nullified_count)
  );

  assign strb = {CplD, Cpl, CfgWr1, CfgRd1, CfgWr0, CfgRd0, IOWr, IORd, MWr, MRd};

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_tlp, exp_err, exp_null;

  typedef struct {
    int         n_bytes;
    logic [7:0] type_byte;
    logic [7:0] term;
    logic       exp_valid;
    logic [3:0] exp_kind;
    int         add_err;
    int         add_null;
  } vec_t;

  vec_t vecs [17];

  function automatic logic [7:0] pat(int i, logic [7:0] t);
    if (i == TYPE_OFFSET) return t;
    return 8'(8'h31 + 7 * i);
  endfunction

  function automatic logic [DW-1:0] frame_image(int n, logic [7:0] t);
    logic [DW-1:0] d;
    d = '0;
    for (int i = 0; i < n && i < MAX_BYTES; i++) d[i*8 +: 8] = pat(i, t);
    return d;
  endfunction

  function automatic logic [9:0] strobe_image(logic v, logic [3:0] k);
    if (!v || k > 4'd9) return 10'd0;
    return 10'd1 << k;
  endfunction

  task automatic checkOutput(string name, logic [DW-1:0] actual, logic [DW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic drive(logic k, logic [7:0] d);
    @(negedge clk);
    datak   = k;
    data_in = d;
  endtask

  // STP, n data bytes, terminator; ready takes rdy_at_end in the terminator cycle.
  task automatic applyStimulus(int n, logic [7:0] t, logic [7:0] term, logic rdy_at_end);
    drive(1'b1, STP);
    for (int i = 0; i < n; i++) drive(1'b0, pat(i, t));
    @(negedge clk);
    tlp_bus.tlp_ready = rdy_at_end;
    datak   = 1'b1;
    data_in = term;
    @(posedge clk);
    #1;
  endtask

  task automatic check_counts(string tag, int t, int e, int d, int nl);
    checkOutput({tag, " tlp_count"},       DW'(tlp_count),       DW'(t));
    checkOutput({tag, " err_count"},       DW'(err_count),       DW'(e));
    checkOutput({tag, " drop_count"},      DW'(drop_count),      DW'(d));
    checkOutput({tag, " nullified_count"}, DW'(nullified_count), DW'(nl));
  endtask

  task automatic check_held(string tag, logic [DW-1:0] d, int n, logic [3:0] k);
    checkOutput({tag, " valid"},   DW'(tlp_bus.tlp_valid), DW'(1));
    checkOutput({tag, " data"},    tlp_bus.tlp_data,       d);
    checkOutput({tag, " len"},     DW'(tlp_bus.tlp_len),   DW'(n));
    checkOutput({tag, " kind"},    DW'(tlp_bus.tlp_kind),  DW'(k));
    checkOutput({tag, " strobes"}, DW'(strb),              DW'(strobe_image(1'b1, k)));
  endtask

  task automatic check_idle(string tag);
    checkOutput({tag, " valid"},   DW'(tlp_bus.tlp_valid), '0);
    checkOutput({tag, " data"},    tlp_bus.tlp_data,       '0);
    checkOutput({tag, " len"},     DW'(tlp_bus.tlp_len),   '0);
    checkOutput({tag, " kind"},    DW'(tlp_bus.tlp_kind),  '0);
    checkOutput({tag, " strobes"}, DW'(strb),              '0);
    check_counts(tag, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    reset   = 1'b0;
    datak   = 1'b0;
    data_in = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = '{12, 8'h40, END, 1'b1, MWR,     0, 0};
    vecs[1]  = '{20, 8'h4A, END, 1'b1, CPLD,    0, 0};
    vecs[2]  = '{20, 8'h00, END, 1'b1, MRD,     0, 0};
    vecs[3]  = '{5,  8'h00, END, 1'b0, MRD,     1, 0};
    vecs[4]  = '{21, 8'h40, END, 1'b0, MRD,     1, 0};
    vecs[5]  = '{14, 8'h40, EDB, 1'b0, MRD,     0, 1};
    vecs[6]  = '{11, 8'h04, END, 1'b0, MRD,     1, 0};
    vecs[7]  = '{13, 8'h02, END, 1'b1, IORD,    0, 0};
    vecs[8]  = '{12, 8'h42, END, 1'b1, IOWR,    0, 0};
    vecs[9]  = '{16, 8'h04, END, 1'b1, CFGRD0,  0, 0};
    vecs[10] = '{12, 8'h44, END, 1'b1, CFGWR0,  0, 0};
    vecs[11] = '{12, 8'h05, END, 1'b1, CFGRD1,  0, 0};
    vecs[12] = '{12, 8'h45, END, 1'b1, CFGWR1,  0, 0};
    vecs[13] = '{12, 8'h0A, END, 1'b1, CPL,     0, 0};
    vecs[14] = '{18, 8'h20, END, 1'b1, MRD,     0, 0};
    vecs[15] = '{12, 8'h60, END, 1'b1, MWR,     0, 0};
    vecs[16] = '{12, 8'h7F, END, 1'b1, UNKNOWN, 0, 0};

    tlp_bus.tlp_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_idle("reset");
    @(negedge clk);
    reset = 1'b1;

    // Frames run back to back: each STP follows the previous terminator directly.
    exp_tlp = 0; exp_err = 0; exp_null = 0;
    for (int v = 0; v < 17; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      applyStimulus(vecs[v].n_bytes, vecs[v].type_byte, vecs[v].term, 1'b1);
      exp_tlp  += vecs[v].exp_valid ? 1 : 0;
      exp_err  += vecs[v].add_err;
      exp_null += vecs[v].add_null;
      if (vecs[v].exp_valid) begin
        check_held(tag, frame_image(vecs[v].n_bytes, vecs[v].type_byte),
                   vecs[v].n_bytes, vecs[v].exp_kind);
      end else begin
        checkOutput({tag, " valid"},   DW'(tlp_bus.tlp_valid), '0);
        checkOutput({tag, " strobes"}, DW'(strb),              '0);
      end
      check_counts(tag, exp_tlp, exp_err, 0, exp_null);
    end

    // STP inside a frame restarts it; a stray K symbol sends it to DISCARD.
    do_reset();
    drive(1'b1, STP);
    for (int i = 0; i < 3; i++) drive(1'b0, 8'hC0);
    applyStimulus(12, 8'h40, END, 1'b1);
    check_held("restart", frame_image(12, 8'h40), 12, MWR);
    check_counts("restart", 1, 1, 0, 0);
    drive(1'b1, STP);
    for (int i = 0; i < 4; i++) drive(1'b0, 8'h11);
    drive(1'b1, 8'hBC);
    for (int i = 0; i < 3; i++) drive(1'b0, 8'h22);
    drive(1'b1, END);
    @(posedge clk);
    #1;
    checkOutput("badk valid", DW'(tlp_bus.tlp_valid), '0);
    check_counts("badk", 1, 2, 0, 0);
    drive(1'b1, STP);
    for (int i = 0; i < 2; i++) drive(1'b0, 8'h33);
    drive(1'b1, 8'h1C);
    applyStimulus(12, 8'h0A, END, 1'b1);
    check_held("discard_stp", frame_image(12, 8'h0A), 12, CPL);
    check_counts("discard_stp", 2, 3, 0, 0);

    // Backpressure: first TLP held, two drops, then pop-and-load on the fourth.
    do_reset();
    tlp_bus.tlp_ready = 1'b0;
    applyStimulus(12, 8'h40, END, 1'b0);
    check_held("bp1", frame_image(12, 8'h40), 12, MWR);
    check_counts("bp1", 1, 0, 0, 0);
    applyStimulus(15, 8'h00, END, 1'b0);
    check_held("bp2", frame_image(12, 8'h40), 12, MWR);
    check_counts("bp2", 1, 0, 1, 0);
    applyStimulus(12, 8'h0A, END, 1'b0);
    check_held("bp3", frame_image(12, 8'h40), 12, MWR);
    check_counts("bp3", 1, 0, 2, 0);
    applyStimulus(20, 8'h4A, END, 1'b1);
    check_held("bp4", frame_image(20, 8'h4A), 20, CPLD);
    check_counts("bp4", 2, 0, 2, 0);
    @(posedge clk);
    #1;
    checkOutput("bp_pop valid",   DW'(tlp_bus.tlp_valid), '0);
    checkOutput("bp_pop strobes", DW'(strb),              '0);

    // Reset in the middle of a frame while a TLP is held.
    tlp_bus.tlp_ready = 1'b0;
    applyStimulus(12, 8'h42, END, 1'b0);
    check_held("pre_rst", frame_image(12, 8'h42), 12, IOWR);
    drive(1'b1, STP);
    for (int i = 0; i < 7; i++) drive(1'b0, 8'h44);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_idle("mid_rst");
    @(negedge clk);
    reset = 1'b1;
    tlp_bus.tlp_ready = 1'b1;
    for (int i = 0; i < 5; i++) drive(1'b0, 8'h55);
    drive(1'b1, END);
    @(posedge clk);
    #1;
    checkOutput("post_rst valid", DW'(tlp_bus.tlp_valid), '0);
    check_counts("post_rst", 0, 0, 0, 0);
    applyStimulus(12, 8'h44, END, 1'b1);
    check_held("post_rst_frame", frame_image(12, 8'h44), 12, CFGWR0);
    check_counts("post_rst_frame", 1, 0, 0, 0);

    // 300 runt frames: err_count climbs to FE, then sticks at FF.
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, STP);
      drive(1'b1, END);
      if (i == 253) begin
        @(posedge clk);
        #1;
        checkOutput("err_254", DW'(err_count), DW'(254));
      end
    end
    @(posedge clk);
    #1;
    checkOutput("err_sat valid", DW'(tlp_bus.tlp_valid), '0);
    check_counts("err_sat", 1, 255, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tlp_stream_detector.md
Name: tlp_stream_detector

Overview:
- Byte-serial PCIe symbol-stream TLP detector, next generation of the single-size detector.
- Frames variable-length TLPs between STP and END with parametrised minimum and maximum lengths, and aborts on EDB.
- Flags malformed frames, decodes the fmt/type byte into a kind code plus one-hot strobes, and presents each good TLP on a valid/ready output with a one-entry holding buffer.
- Sits between lane deskew/descrambler and the transaction-layer receive queue.

Parameters:
- MAX_BYTES, 20: maximum payload bytes between STP and END (sequence number, header, data, LCRC); sets data_out width.
- MIN_BYTES, 12: minimum legal byte count.
- TYPE_OFFSET, 2: byte index of the fmt/type byte within the frame (bytes 0-1 are the sequence number).
- CNT_W, 8: width of the statistics counters.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- data_in  in  8  received symbol
- datak  in  1  data_in is a K symbol
- tlp_ready  in  1  downstream accepts the TLP this cycle
- tlp_valid  out  1  holding buffer contains a TLP
- tlp_data  out  MAX_BYTES*8  frame bytes; byte 0 in [7:0]; unused upper bytes zero
- tlp_len  out  $clog2(MAX_BYTES+1)  byte count of the held TLP
- tlp_kind  out  4  decoded kind (package enum)
- MRd, MWr, IORd, IOWr, CfgRd0, CfgWr0, CfgRd1, CfgWr1, Cpl, CplD  out  1 each  one-hot of tlp_kind, gated by tlp_valid
- tlp_count  out  CNT_W  good TLPs loaded into the buffer
- err_count  out  CNT_W  malformed frames
- drop_count  out  CNT_W  good TLPs lost to a full buffer
- nullified_count  out  CNT_W  frames ended by EDB

Behaviour:
- Reset: all outputs 0, state IDLE, buffer empty.
- K-symbol codes: STP = FB, END = FD, EDB = FE, qualified by datak=1.
- IDLE:
  - STP -> FRAME; clear the byte index and the assembly register.
  - All other symbols are ignored.
- FRAME:
  - Data byte (datak=0) with index < MAX_BYTES: store at the index position, index+1.
  - Data byte with index = MAX_BYTES: err_count+1 -> DISCARD.
  - END with MIN_BYTES <= index <= MAX_BYTES: frame complete -> IDLE.
  - END with index < MIN_BYTES: err_count+1 -> IDLE.
  - EDB: nullified_count+1 -> IDLE; the frame is discarded silently.
  - STP: err_count+1; discard the partial frame and restart FRAME with index 0.
  - Any other K symbol: err_count+1 -> DISCARD.
- DISCARD:
  - Ignore bytes until END or EDB -> IDLE, with no further counting.
  - STP -> FRAME, restart.
- Back-to-back frames: END in cycle n and STP in cycle n+1 must be accepted with no dead cycle.
- Completion (END cycle):
  - Load the buffer if it is empty, or if tlp_valid & tlp_ready in the same cycle (pop and load simultaneously). Then tlp_count+1.
  - Otherwise drop the frame and drop_count+1; the buffer contents are unchanged.
- Latency: tlp_valid is high in the cycle after END is sampled.
- Handshake:
  - tlp_data, tlp_len and tlp_kind are stable while tlp_valid & !tlp_ready.
  - Transfer occurs on tlp_valid & tlp_ready; if no load happens that cycle, tlp_valid falls next cycle.
- Kind decode of byte TYPE_OFFSET:
  - 00/20 = MRd, 40/60 = MWr
  - 02 = IORd, 42 = IOWr
  - 04 = CfgRd0, 44 = CfgWr0, 05 = CfgRd1, 45 = CfgWr1
  - 0A = Cpl, 4A = CplD
  - anything else = UNKNOWN (15), which is still delivered with no strobe asserted.
  - The decode is registered together with the data.
- Counters saturate at all-ones; they never wrap.
- Reset mid-frame: the partial frame is discarded, the buffer is emptied and the counters are zeroed.

Decomposition:
- Shared package tlp_pkg holds:
  - K-code constants STP, END, EDB
  - the tlp_kind enum: MRD=0, MWR=1, IORD=2, IOWR=3, CFGRD0=4, CFGWR0=5, CFGRD1=6, CFGWR1=7, CPL=8, CPLD=9, UNKNOWN=15
  - the fmt/type byte encodings
- Sub-module tlp_type_decoder (combinational): byte in -> kind out.
- Counters reuse the existing up_down_counter with a saturation wrapper, or are written inline.

Test Plan:
- STP, 12 bytes with byte2=40, END; tlp_ready=1 -> tlp_valid for 1 cycle; tlp_len=12, MWr=1, tlp_kind=1, tlp_count=1.
- Two 20-byte frames back-to-back (END then STP next cycle), byte2=4A then 00 -> two transfers: CplD then MRd; tlp_count=2, err_count=0.
- STP, 5 bytes, END -> no tlp_valid, err_count=1. STP, 21 bytes, END -> err_count=2, no delivery.
- STP, 14 bytes, EDB -> nullified_count=1, no tlp_valid. STP, 3 bytes, STP, 12 bytes, END -> err_count=1, one delivery with tlp_len=12.
- tlp_ready held 0, three good frames -> first is held with tlp_data stable, drop_count=2. Then raise tlp_ready in the END cycle of a fourth frame -> pop and load, tlp_valid stays 1.
- Assert reset mid-frame after 7 bytes -> all outputs 0; next complete frame delivers with tlp_count=1. Force 300 errors -> err_count=FF (saturated).
